generic_fifo_flex: RTL

Parametrised successor to the team's single-clock valid/grant FIFO. Adds the following:
- Arbitrary (non-power-of-2) depth.
- Optional fall-through mode.
- Occupancy count, almost-full and almost-empty flags.
- Synchronous flush.

It sits between address decoders/allocators and their consumers wherever destination or payload buffering with back-pressure is needed. Storage is plain flip-flops with no clock gating.

---
 rtl/generic_fifo_flex_pkg.sv | 20 ++
 rtl/fifo_ptr_wrap.sv | 41 ++++
 rtl/generic_fifo_flex.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/generic_fifo_flex_pkg.sv
// ----------------------------------------------------------------------------
// generic_fifo_flex_pkg
// Purpose : width helpers shared by the flexible FIFO and its pointer counter.
//           Every other width is derived locally from module parameters.
// Contents: fifo_ptr_w(depth) - pointer width, never less than one bit
//           fifo_cnt_w(depth) - occupancy width able to hold 0..depth
// ----------------------------------------------------------------------------
package generic_fifo_flex_pkg;

  // A single-entry FIFO still needs a one-bit pointer so the port exists.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent the full state, hence depth+1 codes.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// ----------------------------------------------------------------------------
// fifo_ptr_wrap
// Purpose : modulo-DATA_DEPTH pointer used for both FIFO read and write
//           sides. Works for any depth, not only powers of two.
// Ports   : clk    - clock, rising edge
//           rst    - synchronous active-high reset, pointer to 0
//           clr_i  - synchronous clear, pointer to 0
//           inc_i  - advance the pointer by one, wrapping after DATA_DEPTH-1
//           ptr_o  - current pointer value, always in 0..DATA_DEPTH-1
// ----------------------------------------------------------------------------
module fifo_ptr_wrap
  import generic_fifo_flex_pkg::*;
#(
  parameter  int DATA_DEPTH = 8,
  localparam int PTR_W      = fifo_ptr_w(DATA_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DATA_DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

  logic [PTR_W-1:0] r_ptr;

  // Explicit wrap at the last entry keeps non-power-of-2 depths in range;
  // for DATA_DEPTH==1 LAST is 0 so the pointer never leaves 0.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + ONE;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/generic_fifo_flex.sv
// ----------------------------------------------------------------------------
// generic_fifo_flex
// Purpose : single-clock valid/grant FIFO with arbitrary depth, optional
//           fall-through when empty, occupancy count, almost-full /
//           almost-empty flags and a synchronous flush. Flip-flop storage.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           flush_i               - drop all contents (storage not cleared)
//           data_i/valid_i/grant_o - push side; grant_o == !full_o
//           data_o/valid_o/grant_i - pop side
//           usage_o               - entries stored, 0..DATA_DEPTH
//           full_o/empty_o        - usage at DATA_DEPTH / zero
//           alm_full_o            - usage_o >= ALM_FULL_TH
//           alm_empty_o           - usage_o <= ALM_EMPTY_TH
// ----------------------------------------------------------------------------
module generic_fifo_flex
  import generic_fifo_flex_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DATA_DEPTH   = 8,
  parameter  int FALL_THROUGH = 0,
  parameter  int ALM_FULL_TH  = DATA_DEPTH - 1,
  parameter  int ALM_EMPTY_TH = 1,
  localparam int PTR_W        = fifo_ptr_w(DATA_DEPTH),
  localparam int CNT_W        = fifo_cnt_w(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  alm_full_o,
  output logic                  alm_empty_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DATA_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALM_FULL_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALM_EMPTY_TH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam bit               FT      = (FALL_THROUGH != 0);

  // Elaboration-time parameter sanity checks.
  if (DATA_WIDTH < 1) begin : g_chk_width
    $error("generic_fifo_flex: DATA_WIDTH must be >= 1");
  end
  if (DATA_DEPTH < 1) begin : g_chk_depth
    $error("generic_fifo_flex: DATA_DEPTH must be >= 1");
  end
  if (ALM_FULL_TH > DATA_DEPTH) begin : g_chk_af
    $error("generic_fifo_flex: ALM_FULL_TH exceeds DATA_DEPTH");
  end
  if (ALM_EMPTY_TH > DATA_DEPTH) begin : g_chk_ae
    $error("generic_fifo_flex: ALM_EMPTY_TH exceeds DATA_DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      w_push_ptr;
  logic [PTR_W-1:0]      w_pop_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  // Status is decoded from the count so full and empty never need the
  // extra pointer wrap bit that a pointer comparison would.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Fall-through bypass: the word goes straight to the consumer and never
  // touches storage, pointers or count.
  assign w_bypass = FT && w_empty && valid_i && grant_i;

  // Flush discards any concurrent transfer even though grant_o may read 1.
  assign w_push = valid_i && !w_full && !w_bypass && !flush_i;
  assign w_pop  = !w_empty && grant_i && !flush_i;

  fifo_ptr_wrap #(
    .DATA_DEPTH (DATA_DEPTH)
  ) u_push_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .inc_i (w_push),
    .ptr_o (w_push_ptr)
  );

  fifo_ptr_wrap #(
    .DATA_DEPTH (DATA_DEPTH)
  ) u_pop_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .inc_i (w_pop),
    .ptr_o (w_pop_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared only by reset; flush leaves stale words behind, which
  // are unreachable because the count drops to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_push_ptr] <= data_i;
    end
  end

  assign grant_o     = !w_full;
  assign valid_o     = FT ? (!w_empty || valid_i) : !w_empty;
  // When empty without fall-through this shows storage[pop_ptr], which is
  // zero after reset; consumers must qualify with valid_o.
  assign data_o      = (FT && w_empty) ? data_i : r_mem[w_pop_ptr];
  assign usage_o     = r_count;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign alm_full_o  = (r_count >= AF_C);
  assign alm_empty_o = (r_count <= AE_C);

  a_no_write_full : assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full))
    else $error("generic_fifo_flex: write while full");

  a_count_max : assert property (@(posedge clk) disable iff (rst)
    (r_count <= DEPTH_C))
    else $error("generic_fifo_flex: count exceeds depth");

  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(w_pop && w_empty))
    else $error("generic_fifo_flex: pop while empty");

endmodule
